// File: rtl/timing_leak_monitor_if.sv
// Trial control and result bus between the stimulus driver (master) and timing_leak_monitor (slave).
// Parameters must match those of the monitor instance it connects to.
interface timing_leak_monitor_if #(
    parameter int COPIES    = 4,
    parameter int CNT_W     = 16,
    parameter int LEAKCNT_W = 8
);
    logic                 start;
    logic [COPIES-1:0]    copy_done;
    logic                 copy_start;
    logic                 busy;
    logic                 done;
    logic                 leak;
    logic                 timeout;
    logic [COPIES-1:0]    done_mask;
    logic [CNT_W-1:0]     min_lat;
    logic [CNT_W-1:0]     max_lat;
    logic [LEAKCNT_W-1:0] leak_count;

    modport master (
        output start, copy_done,
        input  copy_start, busy, done, leak, timeout, done_mask, min_lat, max_lat, leak_count
    );

    modport slave (
        input  start, copy_done,
        output copy_start, busy, done, leak, timeout, done_mask, min_lat, max_lat, leak_count
    );
endinterface

// File: rtl/timing_leak_monitor.sv
// Launches COPIES sequential cores together, records each copy's completion latency and
// flags any divergence between copies (timing leak), with timeout and saturating leak tally.
module timing_leak_monitor #(
    parameter int COPIES    = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024,
    parameter int LEAKCNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    timing_leak_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    localparam logic [COPIES-1:0] ALL_SEEN = '1;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [COPIES-1:0] seen, newArr, seenNext;
    logic [CNT_W-1:0] lat     [COPIES];
    logic [CNT_W-1:0] latNext [COPIES];
    logic [CNT_W-1:0] minNext, maxNext;
    logic             allSeen, atTimeout, finish, leakNext, launch;

    // Arrivals this cycle, and the latency extremes including them
    always_comb begin
        newArr   = bus.copy_done & ~seen;
        seenNext = seen | newArr;
        minNext  = '1;
        maxNext  = '0;
        for (int i = 0; i < COPIES; i++) begin
            latNext[i] = newArr[i] ? cnt : lat[i];
            if (seenNext[i]) begin
                if (latNext[i] < minNext) minNext = latNext[i];
                if (latNext[i] > maxNext) maxNext = latNext[i];
            end
        end
        allSeen   = (seenNext == ALL_SEEN);
        atTimeout = (cnt == CNT_W'(TIMEOUT)) && !allSeen;
        finish    = allSeen || atTimeout;
        // A partial set at timeout is already a divergence: some copies finished, others did not
        leakNext  = allSeen ? (minNext != maxNext) : (|seenNext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        case (state)
            IDLE, REPORT: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (finish) stateNext = REPORT;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held
    assign bus.copy_start = launch & rst;
    assign bus.busy       = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            seen           <= '0;
            for (int i = 0; i < COPIES; i++) lat[i] <= '0;
            bus.done       <= 1'b0;
            bus.leak       <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.done_mask  <= '0;
            bus.min_lat    <= '0;
            bus.max_lat    <= '0;
            bus.leak_count <= '0;
        end else begin
            bus.done <= 1'b0;
            if (launch) begin
                cnt           <= CNT_W'(1);
                seen          <= '0;
                for (int i = 0; i < COPIES; i++) lat[i] <= '0;
                bus.leak      <= 1'b0;
                bus.timeout   <= 1'b0;
                bus.done_mask <= '0;
                bus.min_lat   <= '1;
                bus.max_lat   <= '0;
            end else if (state == RUN) begin
                cnt         <= cnt + CNT_W'(1);
                seen        <= seenNext;
                for (int i = 0; i < COPIES; i++) lat[i] <= latNext[i];
                bus.min_lat <= minNext;
                bus.max_lat <= maxNext;
                if (finish) begin
                    bus.done      <= 1'b1;
                    bus.timeout   <= !allSeen;
                    bus.done_mask <= seenNext;
                    bus.leak      <= leakNext;
                    if (leakNext && (bus.leak_count != '1))
                        bus.leak_count <= bus.leak_count + LEAKCNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_timing_leak_monitor.sv
// Randomized and directed trials of timing_leak_monitor against a trial-level reference model.
module tb_timing_leak_monitor;
    localparam int COPIES    = 4;
    localparam int CNT_W     = 16;
    localparam int TIMEOUT   = 20;
    localparam int LEAKCNT_W = 2;
    localparam int LEAK_MAX  = (1 << LEAKCNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   modelLeakCount = 0;

    timing_leak_monitor_if #(.COPIES(COPIES), .CNT_W(CNT_W), .LEAKCNT_W(LEAKCNT_W)) bus ();

    timing_leak_monitor #(
        .COPIES(COPIES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LEAKCNT_W(LEAKCNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // arr[i]: cycle (counting the copy_start cycle as 0) in which copy i first reports done;
    // values outside 1..TIMEOUT mean the copy never finishes within the trial.
    task automatic model(input int arr[COPIES], output int endCyc, output bit expLeak,
                         output bit expTo, output logic [COPIES-1:0] expMask,
                         output int expMin, output int expMax);
        bit everyone = 1'b1;
        int last = 0;
        for (int i = 0; i < COPIES; i++) begin
            if (arr[i] < 1 || arr[i] > TIMEOUT) everyone = 1'b0;
            else if (arr[i] > last) last = arr[i];
        end
        endCyc  = everyone ? last : TIMEOUT;
        expTo   = !everyone;
        expMask = '0;
        expMin  = (1 << CNT_W) - 1;
        expMax  = 0;
        for (int i = 0; i < COPIES; i++) begin
            if (arr[i] >= 1 && arr[i] <= endCyc) begin
                expMask[i] = 1'b1;
                if (arr[i] < expMin) expMin = arr[i];
                if (arr[i] > expMax) expMax = arr[i];
            end
        end
        expLeak = everyone ? (expMin != expMax) : (expMask != '0);
    endtask

    task automatic runTrial(input string name, input int arr[COPIES],
                            input logic [COPIES-1:0] pulse, input bit holdStart,
                            input bit launched);
        int endCyc, expMin, expMax, doneAt, strayStarts, busyLow;
        bit expLeak, expTo;
        logic [COPIES-1:0] expMask;
        doneAt = 0; strayStarts = 0; busyLow = 0;
        model(arr, endCyc, expLeak, expTo, expMask, expMin, expMax);
        if (expLeak && modelLeakCount < LEAK_MAX) modelLeakCount++;
        if (!launched) begin
            @(negedge clk);
            bus.start = 1'b1;
            #1;
            checks++;
            if (bus.copy_start !== 1'b1) begin
                errors++;
                $display("FAIL %s launch copy_start: got %b want 1", name, bus.copy_start);
            end
        end
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                doneAt = k;
                break;
            end
            if (k == 1) begin
                checks++;
                if (bus.leak !== 1'b0 || bus.timeout !== 1'b0 || bus.done_mask !== '0 ||
                    bus.min_lat !== '1 || bus.max_lat !== '0) begin
                    errors++;
                    $display("FAIL %s cleared: got leak=%b to=%b mask=%b min=%0d max=%0d want 0 0 0 65535 0",
                             name, bus.leak, bus.timeout, bus.done_mask, bus.min_lat, bus.max_lat);
                end
            end
            if (!holdStart) bus.start = 1'b0;
            for (int i = 0; i < COPIES; i++)
                bus.copy_done[i] = pulse[i] ? (arr[i] >= 1 && (k == arr[i] || k == arr[i] + 2))
                                            : (arr[i] >= 1 && k >= arr[i]);
            #1;
            if (bus.copy_start !== 1'b0) strayStarts++;
            if (bus.busy !== 1'b1) busyLow++;
        end
        bus.copy_done = '0;
        checks++;
        if (doneAt == 0) begin
            errors++;
            $display("FAIL %s done_wait: no done pulse within %0d cycles", name, TIMEOUT + 3);
            bus.start = 1'b0;
            return;
        end
        if (doneAt != endCyc + 1) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, doneAt, endCyc + 1);
        end
        checks++;
        if (bus.leak !== expLeak || bus.timeout !== expTo) begin
            errors++;
            $display("FAIL %s leak/timeout: got %b/%b want %b/%b", name, bus.leak, bus.timeout, expLeak, expTo);
        end
        checks++;
        if (bus.done_mask !== expMask) begin
            errors++;
            $display("FAIL %s done_mask: got %b want %b", name, bus.done_mask, expMask);
        end
        checks++;
        if (bus.min_lat !== CNT_W'(expMin) || bus.max_lat !== CNT_W'(expMax)) begin
            errors++;
            $display("FAIL %s min/max: got %0d/%0d want %0d/%0d", name, bus.min_lat, bus.max_lat, expMin, expMax);
        end
        checks++;
        if (bus.leak_count !== LEAKCNT_W'(modelLeakCount)) begin
            errors++;
            $display("FAIL %s leak_count: got %0d want %0d", name, bus.leak_count, modelLeakCount);
        end
        checks++;
        if (strayStarts != 0 || busyLow != 0) begin
            errors++;
            $display("FAIL %s run: got %0d stray copy_start, %0d busy-low cycles want 0, 0",
                     name, strayStarts, busyLow);
        end
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.copy_start !== holdStart) begin
            errors++;
            $display("FAIL %s report: got busy=%b copy_start=%b want 0 %b", name, bus.busy, bus.copy_start, holdStart);
        end
        if (!holdStart) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.done_mask !== expMask || bus.max_lat !== CNT_W'(expMax)) begin
                errors++;
                $display("FAIL %s hold: got done=%b mask=%b max=%0d want 0 %b %0d",
                         name, bus.done, bus.done_mask, bus.max_lat, expMask, expMax);
            end
        end
    endtask

    task automatic checkAllZero(input string name);
        checks++;
        if (bus.copy_start !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.leak !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.done_mask !== '0 || bus.min_lat !== '0 ||
            bus.max_lat !== '0 || bus.leak_count !== '0) begin
            errors++;
            $display("FAIL %s outputs: got cs=%b busy=%b done=%b leak=%b to=%b mask=%b min=%0d max=%0d lc=%0d want all 0",
                     name, bus.copy_start, bus.busy, bus.done, bus.leak, bus.timeout, bus.done_mask,
                     bus.min_lat, bus.max_lat, bus.leak_count);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.copy_done = '1;
        #1;
        checkAllZero("reset");
        repeat (3) @(negedge clk);
        checkAllZero("reset_held");
        bus.start = 1'b0;
        bus.copy_done = '0;
        rst = 1'b1;
        modelLeakCount = 0;
    endtask

    task automatic test_directed();
        runTrial("all_equal", '{5, 5, 5, 5}, 4'b0000, 1'b0, 1'b0);
        runTrial("late_copy3", '{5, 5, 5, 7}, 4'b0101, 1'b0, 1'b0);
        runTrial("timeout_partial", '{9, 9, 0, 9}, 4'b0010, 1'b0, 1'b0);
        runTrial("timeout_none", '{0, 0, 0, 0}, 4'b0000, 1'b0, 1'b0);
        runTrial("finish_at_timeout", '{3, 8, 20, 12}, 4'b1111, 1'b0, 1'b0);
        runTrial("equal_at_timeout", '{20, 20, 20, 20}, 4'b0000, 1'b0, 1'b0);
        runTrial("first_cycle", '{1, 1, 1, 1}, 4'b1010, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        runTrial("held_a", '{4, 6, 4, 4}, 4'b0000, 1'b1, 1'b0);
        runTrial("held_b", '{2, 2, 2, 2}, 4'b1111, 1'b1, 1'b1);
        runTrial("held_c", '{3, 0, 3, 3}, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int t = 0; t < 5; t++)
            runTrial("saturate", '{2, 3 + t, 2, 2}, 4'(t), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int arr[COPIES];
        int base, r;
        for (int t = 0; t < 20; t++) begin
            base = $urandom_range(1, TIMEOUT);
            r = $urandom_range(0, 2);
            for (int i = 0; i < COPIES; i++) begin
                if (r == 0) arr[i] = base;
                else if ($urandom_range(0, 7) == 0) arr[i] = ($urandom_range(0, 1) == 1) ? 0 : TIMEOUT + 5;
                else arr[i] = $urandom_range(1, TIMEOUT);
            end
            runTrial("random", arr, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        int sawDone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.copy_done = 4'b0011;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        rst = 1'b0;
        #1;
        checkAllZero("mid_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) sawDone++;
        end
        checks++;
        if (sawDone != 0) begin
            errors++;
            $display("FAIL mid_reset done: got %0d done cycles want 0", sawDone);
        end
        bus.start = 1'b0;
        bus.copy_done = '0;
        rst = 1'b1;
        modelLeakCount = 0;
        runTrial("after_reset", '{3, 3, 3, 6}, 4'b0000, 1'b0, 1'b0);
        runTrial("after_reset2", '{7, 7, 7, 7}, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.copy_done = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timing_leak_monitor.md
Name: timing_leak_monitor

Overview:
- N-copy successor of the two-copy constant-time tester.
- Launches COPIES instances of a start/productDone sequential core together, measures each copy's completion latency in cycles, and flags any latency divergence (a timing leak).
- Also handles timeouts, reports latency spread, and keeps a saturating count of leaky trials across runs.
- Sits in the verification harness between the stimulus driver and the multiplier cores; the harness wires copy_start/copy_done to the cores.

Parameters:
- COPIES, 4, number of core copies monitored (>=2)
- CNT_W, 16, width of cycle counter and latency fields
- TIMEOUT, 1024, cycle count at which an unfinished trial is abandoned (1..2^CNT_W-1)
- LEAKCNT_W, 8, width of saturating leak counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  trial request; honoured only when not busy
- copy_done  input  COPIES  per-copy productDone from the cores
- copy_start  output  1  one-cycle start pulse to all cores
- busy  output  1  trial in progress (RUN state)
- done  output  1  one-cycle pulse on trial completion or timeout
- leak  output  1  last trial showed a latency mismatch (held until next start)
- timeout  output  1  last trial hit TIMEOUT (held until next start)
- done_mask  output  COPIES  copies that completed in last trial
- min_lat  output  CNT_W  smallest latency among completed copies
- max_lat  output  CNT_W  largest latency among completed copies
- leak_count  output  LEAKCNT_W  number of trials with leak=1, saturating

Behaviour:
- States: IDLE, RUN, REPORT. REPORT behaves like IDLE but holds results.
- Reset (rst=0, async): state=IDLE; all outputs 0; cycle counter 0; per-copy latencies 0.
- Start, IDLE/REPORT: start=1 drives copy_start=1 combinationally in that cycle.
  - Next edge: state=RUN, cnt=1, seen mask=0, leak/timeout/done_mask cleared, min_lat=all-ones, max_lat=0.
- Start, RUN: start is ignored; copy_start stays 0.
- RUN, each cycle:
  - For each copy i with copy_done[i]=1 and not yet seen: set seen[i], lat[i]=cnt.
  - Update min_lat/max_lat from these latencies in the same edge.
  - Later copy_done on a copy already seen is ignored (level or pulse accepted).
  - cnt increments each RUN cycle; it never wraps because TIMEOUT < 2^CNT_W.
- Completion: when seen | new arrivals == all ones, next edge:
  - state=REPORT, done=1 for one cycle, done_mask=all ones.
  - leak=1 iff any two latencies differ, i.e. min_lat != max_lat after the update.
- Timeout: in RUN with cnt==TIMEOUT and not all seen after this cycle's arrivals, next edge:
  - state=REPORT, done=1, timeout=1, done_mask=seen (including this cycle's arrivals).
  - leak=1 iff at least one copy completed; leak=0 if none completed.
- Simultaneous events: an arrival in the TIMEOUT cycle that completes the set counts as completion (timeout=0).
- leak_count increments with the done pulse when leak=1; it holds at 2^LEAKCNT_W-1. Only reset clears it.
- min_lat/max_lat hold after a trial. If done_mask==0 at timeout, min_lat=all-ones and max_lat=0.
- Reset mid-RUN aborts the trial immediately; no done pulse is produced.
- busy=1 exactly in RUN.

Test Plan:
- COPIES=4: start, all copy_done rise at cycle 5 after copy_start -> done pulse at cycle 6, leak=0, min_lat=max_lat=5, done_mask=4'b1111, leak_count=0.
- Copies 0-2 done at cycle 5, copy 3 at cycle 7 -> done one cycle after copy 3; leak=1, min_lat=5, max_lat=7, leak_count=1.
- TIMEOUT=20, copy 2 never asserts, others at 9 -> done after cnt=20; timeout=1, leak=1, done_mask=4'b1011, max_lat=9. With no copies done -> leak=0, done_mask=0.
- start held high throughout a trial -> exactly one copy_start pulse per trial. A new trial starts in the first REPORT cycle with start=1, and results are cleared.
- rst low mid-RUN after 2 copies done -> all outputs 0 asynchronously, no done pulse; the next trial measures latencies from scratch.
- LEAKCNT_W=2, 5 consecutive leaky trials -> leak_count saturates at 3.
